// File: rtl/mem_rd_ctrl_pkg.sv
// Shared definitions for the memory read controller: FSM state encoding
// and timeout counter width.
package mem_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/mem_rd_ctrl_tmo_cnt.sv
// WAIT-phase timeout counter. tc flags that the next enabled increment
// reaches TMO, so the controller can time out in that same cycle.
module tmo_cnt
  import mem_rd_ctrl_pkg::*;
#(
  parameter int unsigned TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TMO - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear wins over enable, otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_rd_ctrl.sv
// CPU-to-memory single read controller: accepts one request, strobes the
// memory, waits for data with a timeout and returns a one-cycle response.
module mem_rd_ctrl
  import mem_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TMO    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_tc;

  tmo_cnt #(
    .TMO(TMO)
  ) u_tmo_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (cnt_tc)
  );

  // next state, address latch, response capture and counter control
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          if (req_addr[0]) begin
            resp_err_d  = 1'b1;
            resp_data_d = '0;
            state_d     = ST_RESP;
          end else begin
            mem_addr_d = req_addr;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!mem_stall) begin
          cnt_clr = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_done) begin
          // data arriving on the timeout cycle still counts as success
          resp_data_d = mem_data;
          resp_err_d  = 1'b0;
          state_d     = ST_RESP;
        end else begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            resp_err_d  = 1'b1;
            resp_data_d = '0;
            state_d     = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // controller registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_rd     = (state_q == ST_ISSUE);
  assign resp_valid = (state_q == ST_RESP);
  assign mem_addr   = mem_addr_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Scoreboard bench for mem_rd_ctrl: expected responses are queued when a
// request is driven and compared when resp_valid is seen.
module tb_mem_rd_ctrl;

  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 16;
  localparam int unsigned TMO_TB  = 15;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          flush;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_stall;
  logic          mem_done;
  logic [DW-1:0] mem_data;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  int            n_vec;
  int            n_err;
  int            cyc;
  int            acc_cyc;
  int            rd_cnt;
  logic [AW-1:0] exp_addr;

  mem_rd_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TMO   (TMO_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .flush     (flush),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_stall (mem_stall),
    .mem_done  (mem_done),
    .mem_data  (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic e, input int lat);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.lat  = lat;
    sb.push_back(x);
  endtask

  // aligned read: stalls ISSUE cycles held off, waits WAIT cycles without done
  task automatic do_read(input logic [AW-1:0] addr, input int stalls, input int waits,
                         input logic [DW-1:0] data);
    push(data, 1'b0, stalls + waits + 3);
    exp_addr  = addr;
    rd_cnt    = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    mem_stall = (stalls > 0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < stalls; i++) tick();
    mem_stall = 1'b0;
    tick();
    for (int i = 0; i < waits; i++) tick();
    mem_done = 1'b1;
    mem_data = data;
    tick();
    mem_done = 1'b0;
    tick();
    chk("rd_strobes", rd_cnt, stalls + 1);
  endtask

  // monitor: accept timestamp, address stability, scoreboard pop
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req_valid && req_ready && !flush) acc_cyc = cyc;
      if (mem_rd) begin
        rd_cnt = rd_cnt + 1;
        chk("mem_addr", mem_addr, exp_addr);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexp_resp", resp_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_err", resp_err, e.err);
          chk("latency", cyc - acc_cyc, e.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; acc_cyc = 0; rd_cnt = 0; exp_addr = '0;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_stall = 1'b0; mem_done = 1'b0; mem_data = '0;

    // power-on reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_data", resp_data, 16'h0000);
    chk("rst_err", resp_err, 1'b0);
    #6 rst = 1'b0;

    // first request accepted on the first edge after reset release
    do_read(16'h0010, 0, 0, 16'hBEEF);

    // misaligned: error response, no strobe
    push('0, 1'b1, 1);
    rd_cnt = 0; req_valid = 1'b1; req_addr = 16'h0011;
    tick();
    req_valid = 1'b0;
    tick();
    chk("misal_rd", rd_cnt, 0);

    // stalled issue, then further data patterns
    do_read(16'h0020, 3, 0, 16'h5A5A);
    do_read(16'hFFFE, 1, 5, 16'hFFFF);
    do_read(16'h0000, 0, 2, 16'h0000);

    // timeout, followed by late done in RESP and IDLE
    push('0, 1'b1, TMO_TB + 2);
    exp_addr = 16'h0030; rd_cnt = 0; req_valid = 1'b1; req_addr = 16'h0030;
    tick();
    req_valid = 1'b0;
    tick();
    repeat (TMO_TB) tick();
    mem_done = 1'b1; mem_data = 16'h7777;
    tick();
    tick();
    mem_done = 1'b0;
    chk("tmo_rd", rd_cnt, 1);
    chk("tmo_ready", req_ready, 1'b1);

    // done on the timeout cycle wins
    do_read(16'h0032, 0, TMO_TB - 1, 16'h0F0F);

    // flush in WAIT, then late done
    exp_addr = 16'h0040; req_valid = 1'b1; req_addr = 16'h0040;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flw_ready", req_ready, 1'b1);
    mem_done = 1'b1; mem_data = 16'h1234;
    tick();
    mem_done = 1'b0;
    do_read(16'h0042, 0, 1, 16'hCAFE);

    // flush in ISSUE while stalled
    exp_addr = 16'h0044; rd_cnt = 0; req_valid = 1'b1; req_addr = 16'h0044; mem_stall = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; mem_stall = 1'b0;
    chk("fli_ready", req_ready, 1'b1);
    chk("fli_rd", rd_cnt, 2);

    // flush in IDLE blocks acceptance
    req_valid = 1'b1; req_addr = 16'h0046; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_ready", req_ready, 1'b1);
    chk("fl_idle_rd", mem_rd, 1'b0);

    // flush in RESP is ignored
    push('0, 1'b1, 1);
    req_valid = 1'b1; req_addr = 16'h0013;
    tick();
    req_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;

    do_read(16'h0048, 0, 0, 16'hA5C3);

    // asynchronous reset mid-WAIT
    exp_addr = 16'h0050; req_valid = 1'b1; req_addr = 16'h0050;
    tick();
    req_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", req_ready, 1'b1);
    chk("arst_valid", resp_valid, 1'b0);
    chk("arst_mem_rd", mem_rd, 1'b0);
    chk("arst_addr", mem_addr, 16'h0000);
    chk("arst_data", resp_data, 16'h0000);
    chk("arst_err", resp_err, 1'b0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    mem_done = 1'b1; mem_data = 16'h9999;
    tick();
    mem_done = 1'b0;
    chk("post_rst_ready", req_ready, 1'b1);
    do_read(16'h0060, 0, 0, 16'h1357);

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_rd_ctrl.md
MEM_RD_CTRL -- requirements
Module: mem_rd_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, request/memory address width.
REQ-002 Parameter DATA_W, default 16, data width.
REQ-003 Parameter TMO, default 15, maximum WAIT cycles before timeout; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  CPU read request present.
REQ-007 req_addr  input  ADDR_W  CPU read byte address.
REQ-008 req_ready  output  1  controller accepts request this cycle.
REQ-009 flush  input  1  abandon in-flight read; no response issued.
REQ-010 resp_valid  output  1  one-cycle pulse, response valid.
REQ-011 resp_data  output  DATA_W  read data; zero when resp_err=1.
REQ-012 resp_err  output  1  misaligned address or timeout.
REQ-013 mem_rd  output  1  one-cycle read strobe to memory.
REQ-014 mem_addr  output  ADDR_W  address presented with mem_rd, held until done or abort.
REQ-015 mem_stall  input  1  memory busy; mem_rd is not accepted.
REQ-016 mem_done  input  1  memory data valid this cycle.
REQ-017 mem_data  input  DATA_W  memory read data, sampled when mem_done=1.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE, req_ready SHALL be 1; all other states SHALL drive req_ready to 0.
REQ-020 In IDLE, req_valid=1 with req_addr[0]=1 SHALL capture resp_err=1 and resp_data=0 and go to RESP, with no mem_rd.
REQ-021 In IDLE, req_valid=1 with an aligned address SHALL latch the address into mem_addr and go to ISSUE.
REQ-022 In ISSUE, mem_rd SHALL be 1; mem_stall=1 SHALL keep ISSUE; mem_stall=0 SHALL go to WAIT and clear the timeout counter.
REQ-023 In WAIT, mem_done=1 SHALL capture mem_data into resp_data, set resp_err=0 and go to RESP.
REQ-024 In WAIT without mem_done, the 8-bit counter SHALL increment; when it reaches TMO, resp_err=1, resp_data=0 and the FSM SHALL go to RESP.
REQ-025 mem_done arriving in the same cycle the timeout is reached SHALL win: data is returned with no error.
REQ-026 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-027 Minimum latency SHALL be 3 cycles from request acceptance to resp_valid (mem_done in the first WAIT cycle).
REQ-028 flush=1 in ISSUE or WAIT SHALL return the FSM to IDLE next cycle with no resp_valid.
REQ-029 flush=1 in IDLE SHALL block acceptance that cycle.
REQ-030 flush in RESP SHALL be ignored; the response completes.
REQ-031 mem_done outside WAIT SHALL be ignored, including a late done after a flush or timeout.
REQ-032 resp_data and resp_err SHALL hold their values until the next capture.

Reset
REQ-033 rst=1 SHALL immediately force IDLE with counter=0, mem_addr=0, resp_data=0, resp_err=0, resp_valid=0 and mem_rd=0, independent of clk.
REQ-034 rst asserted mid-read SHALL abandon the read; a subsequent mem_done SHALL be ignored.
REQ-035 The first request after deassertion SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-036 The state encoding (2-bit) and the IDLE/ISSUE/WAIT/RESP localparams SHALL live in the shared CPU definitions include file.
REQ-037 The timeout counter SHALL be one sub-module, tmo_cnt, with clear, enable and terminal-count inputs/outputs.
REQ-038 All flops SHALL use the common asynchronous-reset register style; no latches.

Verification
REQ-039 Aligned read with addr 0x0010, no stall, mem_done one cycle after the strobe with data 0xBEEF -> resp_valid pulse, resp_data=0xBEEF, resp_err=0, 3-cycle latency.
REQ-040 Request with addr 0x0011 -> resp_valid with resp_err=1, resp_data=0, mem_rd never asserted.
REQ-041 mem_stall held high for 3 cycles -> mem_rd high for 4 cycles with mem_addr stable, then normal completion.
REQ-042 No mem_done with TMO=15 -> resp_err=1 after 15 WAIT cycles; a done injected at count 15 -> data returned with resp_err=0.
REQ-043 flush in WAIT followed by a late mem_done with data 0x1234 -> no resp_valid; the next request completes with correct data.
REQ-044 rst pulsed asynchronously between clock edges during WAIT -> all outputs zero immediately, state IDLE, req_ready=1.
